seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_scan_decoder_pkg.sv | 34 +++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 179 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_decoder_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan decoder.
// Patterns are active-low: bit0 = segment a through bit6 = segment g.
package seg7_scan_decoder_pkg;

   localparam int unsigned SEG_W  = 7;
   localparam int unsigned CODE_W = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned ERR_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } state_e;

   localparam logic [SEG_W-1:0] PAT_0     = 7'h40;
   localparam logic [SEG_W-1:0] PAT_1     = 7'h79;
   localparam logic [SEG_W-1:0] PAT_2     = 7'h24;
   localparam logic [SEG_W-1:0] PAT_3     = 7'h30;
   localparam logic [SEG_W-1:0] PAT_4     = 7'h19;
   localparam logic [SEG_W-1:0] PAT_5     = 7'h12;
   localparam logic [SEG_W-1:0] PAT_6     = 7'h02;
   localparam logic [SEG_W-1:0] PAT_7     = 7'h78;
   localparam logic [SEG_W-1:0] PAT_8     = 7'h00;
   localparam logic [SEG_W-1:0] PAT_9     = 7'h10;
   localparam logic [SEG_W-1:0] PAT_DASH  = 7'h3F;
   localparam logic [SEG_W-1:0] PAT_BLANK = 7'h7F;

   localparam logic [CODE_W-1:0] CODE_DASH  = 4'hA;
   localparam logic [CODE_W-1:0] CODE_BLANK = 4'hB;
   localparam logic [CODE_W-1:0] CODE_ERR   = 4'hF;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map from an active-low 7-segment pattern to a 4-bit code.
// Digits give 0..9, dash and blank give their own codes, anything else CODE_ERR.
module seg7_pattern_decode
   import seg7_scan_decoder_pkg::*;
(
   input  logic [SEG_W-1:0]  pattern,
   output logic [CODE_W-1:0] code_c
);

   always_comb begin
      code_c = CODE_ERR;
      case (pattern)
         PAT_0:     code_c = 4'h0;
         PAT_1:     code_c = 4'h1;
         PAT_2:     code_c = 4'h2;
         PAT_3:     code_c = 4'h3;
         PAT_4:     code_c = 4'h4;
         PAT_5:     code_c = 4'h5;
         PAT_6:     code_c = 4'h6;
         PAT_7:     code_c = 4'h7;
         PAT_8:     code_c = 4'h8;
         PAT_9:     code_c = 4'h9;
         PAT_DASH:  code_c = CODE_DASH;
         PAT_BLANK: code_c = CODE_BLANK;
         default:   code_c = CODE_ERR;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the digit codes of a scanned, multiplexed 7-segment display bus.
// Optional SEG7_ERRCNT_EN adds a saturating err_count output.
module seg7_scan_decoder
   import seg7_scan_decoder_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [SEG_W-1:0]             segment,
   input  logic [NUM_DIGITS-1:0]        digit_sel,
   output logic [CODE_W*NUM_DIGITS-1:0] bcd_word,
   output logic [NUM_DIGITS-1:0]        digit_valid,
   output logic                         frame_valid,
   output logic                         pattern_err
`ifdef SEG7_ERRCNT_EN
   ,
   output logic [ERR_W-1:0]             err_count
`endif
);

   localparam int unsigned WORD_W = CODE_W * NUM_DIGITS;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

   state_e state_q, state_d;

   logic [SEG_W-1:0]      seg_q, seg_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic [SEG_W-1:0]      prev_seg_q, prev_seg_d;
   logic [NUM_DIGITS-1:0] prev_sel_q, prev_sel_d;
   logic [NUM_DIGITS-1:0] hold_sel_q, hold_sel_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [WORD_W-1:0]     shadow_q, shadow_d;
   logic [WORD_W-1:0]     bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0] dv_q, dv_d;
   logic                  fv_q, fv_d;
   logic                  perr_q, perr_d;

   logic [NUM_DIGITS-1:0] sel_inv_c;
   logic                  onehot_c;
   logic                  stable_c;
   logic                  sel_new_c;
   logic                  capture_c;
   logic                  frame_go_c;
   logic [CODE_W-1:0]     cap_code_c;

   // Input register stage plus a one-cycle-old copy for stability compare
   always_comb begin
      seg_d      = segment;
      sel_d      = digit_sel;
      prev_seg_d = seg_q;
      prev_sel_d = sel_q;
   end

   always_comb begin
      sel_inv_c = ~sel_q;
      onehot_c  = (sel_inv_c != '0) &&
                  ((sel_inv_c & (sel_inv_c - NUM_DIGITS'(1))) == '0);
      stable_c  = (sel_q == prev_sel_q) && (seg_q == prev_seg_q);
      sel_new_c = (sel_q != hold_sel_q);
   end

   // Captured value comes from the delayed copy: it is the pair that was
   // proven stable, immune to a pin change landing on the CAPTURE cycle.
   seg7_pattern_decode u_decode (
      .pattern (prev_seg_q),
      .code_c  (cap_code_c)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (onehot_c) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (!onehot_c)                         state_d = ST_IDLE;
            else if (stable_c && cnt_q == CNT_LAST) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!onehot_c)      state_d = ST_IDLE;
            else if (sel_new_c) state_d = ST_SETTLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: stability counter and capture strobe
   always_comb begin
      cnt_d     = '0;
      capture_c = 1'b0;
      case (state_q)
         ST_SETTLE:  cnt_d = stable_c ? cnt_q + CNT_W'(1) : '0;
         ST_CAPTURE: capture_c = 1'b1;
         default:    cnt_d = '0;
      endcase
   end

   // Shadow slots, frame publish and error pulse
   always_comb begin
      frame_go_c = &dv_q;
      shadow_d   = shadow_q;
      hold_sel_d = hold_sel_q;
      bcd_d      = frame_go_c ? shadow_q : bcd_q;
      dv_d       = frame_go_c ? '0 : dv_q;
      fv_d       = frame_go_c;
      perr_d     = 1'b0;
      if (capture_c) begin
         for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (!prev_sel_q[k]) shadow_d[CODE_W*k +: CODE_W] = cap_code_c;
         end
         dv_d       = dv_d | ~prev_sel_q;
         hold_sel_d = prev_sel_q;
         perr_d     = (cap_code_c == CODE_ERR);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seg_q      <= '1;
         sel_q      <= '1;
         prev_seg_q <= '1;
         prev_sel_q <= '1;
         hold_sel_q <= '1;
         cnt_q      <= '0;
         shadow_q   <= '0;
         bcd_q      <= {NUM_DIGITS{CODE_BLANK}};
         dv_q       <= '0;
         fv_q       <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         seg_q      <= seg_d;
         sel_q      <= sel_d;
         prev_seg_q <= prev_seg_d;
         prev_sel_q <= prev_sel_d;
         hold_sel_q <= hold_sel_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         bcd_q      <= bcd_d;
         dv_q       <= dv_d;
         fv_q       <= fv_d;
         perr_q     <= perr_d;
      end
   end

   assign bcd_word    = bcd_q;
   assign digit_valid = dv_q;
   assign frame_valid = fv_q;
   assign pattern_err = perr_q;

`ifdef SEG7_ERRCNT_EN
   logic [ERR_W-1:0] errcnt_q, errcnt_d;

   // Saturating count of undecodable captures, aligned with pattern_err
   always_comb begin
      errcnt_d = errcnt_q;
      if (perr_d && errcnt_q != '1) errcnt_d = errcnt_q + ERR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) errcnt_q <= '0;
      else       errcnt_q <= errcnt_d;
   end

   assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: table of scan steps plus hand-written
// sequences for non-one-hot select, unstable segments, latency and reset.
module tb_seg7_scan_decoder;
   import seg7_scan_decoder_pkg::*;

   localparam int unsigned ND = 4;
   localparam int unsigned SC = 8;
   localparam logic [3:0] D0 = 4'b1110;
   localparam logic [3:0] D1 = 4'b1101;
   localparam logic [3:0] D2 = 4'b1011;
   localparam logic [3:0] D3 = 4'b0111;
   localparam logic [3:0] NOSEL = 4'b1111;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  segment;
   logic [3:0]  digit_sel;
   logic [15:0] bcd_word;
   logic [3:0]  digit_valid;
   logic        frame_valid;
   logic        pattern_err;
`ifdef SEG7_ERRCNT_EN
   logic [7:0]  err_count;
`endif

   seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk         (clk),
      .reset       (reset),
      .segment     (segment),
      .digit_sel   (digit_sel),
      .bcd_word    (bcd_word),
      .digit_valid (digit_valid),
      .frame_valid (frame_valid),
      .pattern_err (pattern_err)
`ifdef SEG7_ERRCNT_EN
      ,
      .err_count   (err_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int fv_cnt = 0;
   int pe_cnt = 0;

   always @(negedge clk) begin
      if (frame_valid) fv_cnt++;
      if (pattern_err) pe_cnt++;
   end

   typedef struct {
      logic [3:0]  sel;
      logic [6:0]  seg;
      int          hold;
      logic [3:0]  exp_dv;
      logic [15:0] exp_bcd;
      int          exp_fv;
      int          exp_pe;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int hold);
      digit_sel = sel;
      segment   = seg;
      repeat (hold) @(negedge clk);
      #1;
   endtask

   initial begin
      logic left_idle;
      logic dv_seen;
      int   lat;

      vecs[0]  = '{D0, 7'h79, 20, 4'b0001, 16'hBBBB, 0, 0};
      vecs[1]  = '{D1, 7'h24, 20, 4'b0011, 16'hBBBB, 0, 0};
      vecs[2]  = '{D2, 7'h30, 20, 4'b0111, 16'hBBBB, 0, 0};
      vecs[3]  = '{D3, 7'h19, 20, 4'b0000, 16'h4321, 1, 0};
      vecs[4]  = '{D0, 7'h40, 20, 4'b0001, 16'h4321, 1, 0};
      vecs[5]  = '{D1, 7'h79, 20, 4'b0011, 16'h4321, 1, 0};
      vecs[6]  = '{D2, 7'h7E, 20, 4'b0111, 16'h4321, 1, 1};
      vecs[7]  = '{D3, 7'h24, 20, 4'b0000, 16'h2F10, 2, 1};
      vecs[8]  = '{D0, 7'h3F, 20, 4'b0001, 16'h2F10, 2, 1};
      vecs[9]  = '{D1, 7'h7F, 20, 4'b0011, 16'h2F10, 2, 1};
      vecs[10] = '{D2, 7'h12, 20, 4'b0111, 16'h2F10, 2, 1};
      vecs[11] = '{D3, 7'h02, 20, 4'b0000, 16'h65BA, 3, 1};

      reset     = 1'b1;
      digit_sel = NOSEL;
      segment   = 7'h7F;
      repeat (3) @(negedge clk);
      #1;
      check("rst_bcd", 32'(bcd_word), 32'h0000BBBB);
      check("rst_dv", 32'(digit_valid), 32'h0);
      check("rst_fv", 32'(frame_valid), 32'h0);
      check("rst_pe", 32'(pattern_err), 32'h0);
      reset = 1'b0;
      drive(NOSEL, 7'h7F, 3);

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].sel, vecs[i].seg, vecs[i].hold);
         check($sformatf("v%0d_dv", i), 32'(digit_valid), 32'(vecs[i].exp_dv));
         check($sformatf("v%0d_bcd", i), 32'(bcd_word), 32'(vecs[i].exp_bcd));
         check($sformatf("v%0d_fv", i), 32'(fv_cnt), 32'(vecs[i].exp_fv));
         check($sformatf("v%0d_pe", i), 32'(pe_cnt), 32'(vecs[i].exp_pe));
      end
`ifdef SEG7_ERRCNT_EN
      check("err_count", 32'(err_count), 32'h1);
`endif

      // Two low select bits: must never leave IDLE
      digit_sel = 4'b0011;
      segment   = 7'h40;
      left_idle = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if (i > 1 && dut.state_q != ST_IDLE) left_idle = 1'b1;
      end
      check("multi_sel_idle", 32'(left_idle), 32'h0);
      check("multi_sel_dv", 32'(digit_valid), 32'h0);
      check("multi_sel_bcd", 32'(bcd_word), 32'h000065BA);

      // Segment toggling every 5 cycles never settles long enough
      digit_sel = D1;
      dv_seen   = 1'b0;
      for (int w = 0; w < 8; w++) begin
         segment = (w % 2 == 1) ? 7'h24 : 7'h79;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (digit_valid != 4'b0000) dv_seen = 1'b1;
         end
      end
      check("toggle_dv", 32'(dv_seen), 32'h0);
      check("toggle_pe", 32'(pe_cnt), 32'h1);
      drive(NOSEL, 7'h7F, 4);

      // Pin change to digit_valid visible: 1 + STABLE_CYCLES to CAPTURE, +1 register
      digit_sel = D0;
      segment   = 7'h40;
      lat       = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         #1;
         if (digit_valid[0]) begin
            lat = i;
            break;
         end
      end
      check("latency", 32'(lat), 32'(SC + 2));

      // Reset mid-frame (3 captured, 4th in SETTLE) discards the partial frame
      drive(D1, 7'h79, 20);
      drive(D2, 7'h24, 20);
      check("pre_rst_dv", 32'(digit_valid), 32'h7);
      drive(D3, 7'h30, 5);
      reset = 1'b1;
      drive(NOSEL, 7'h7F, 2);
      check("mid_rst_dv", 32'(digit_valid), 32'h0);
      check("mid_rst_bcd", 32'(bcd_word), 32'h0000BBBB);
      reset = 1'b0;
      drive(D0, 7'h19, 20);
      drive(D1, 7'h30, 20);
      drive(D2, 7'h24, 20);
      check("fresh3_dv", 32'(digit_valid), 32'h7);
      check("fresh3_fv", 32'(fv_cnt), 32'd3);
      check("fresh3_bcd", 32'(bcd_word), 32'h0000BBBB);
      drive(D3, 7'h79, 20);
      check("fresh4_fv", 32'(fv_cnt), 32'd4);
      check("fresh4_bcd", 32'(bcd_word), 32'h00001234);
      check("fresh4_dv", 32'(digit_valid), 32'h0);
      check("final_pe", 32'(pe_cnt), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
